// File: rtl/bip_control.sv
// BIP instruction-sequencing control: PC, two-phase FETCH/EXEC/HALT sequencer and
// opcode decode driving the BAU op select, accumulator/operand muxes and RAM strobes.
module bip_control #(
   parameter int msb = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           run,
   input  logic [msb+5:0] instr,
   output logic [msb:0]   pm_addr,
   output logic [msb:0]   operand,
   output logic           op,
   output logic [1:0]     sel_a,
   output logic           sel_b,
   output logic           wr_acc,
   output logic           wr_ram,
   output logic           rd_ram,
   output logic           halted,
   output logic [15:0]    cycle_count
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [4:0] OP_HLT  = 5'd0;
   localparam logic [4:0] OP_STO  = 5'd1;
   localparam logic [4:0] OP_LD   = 5'd2;
   localparam logic [4:0] OP_LDI  = 5'd3;
   localparam logic [4:0] OP_ADD  = 5'd4;
   localparam logic [4:0] OP_ADDI = 5'd5;
   localparam logic [4:0] OP_SUB  = 5'd6;
   localparam logic [4:0] OP_SUBI = 5'd7;

   localparam logic [msb:0] PC_ONE = {{msb{1'b0}}, 1'b1};

   state_t        state_r;
   state_t        state_s;
   logic [msb:0]  pc_r;
   logic [msb:0]  pc_s;
   logic [15:0]   count_r;
   logic [15:0]   count_s;
   logic [4:0]    opcode_s;
   logic [msb:0]  operand_s;
   logic          op_s;
   logic [1:0]    sel_a_s;
   logic          sel_b_s;
   logic          dec_wr_acc_s;
   logic          dec_wr_ram_s;
   logic          dec_rd_ram_s;

   assign opcode_s = instr[msb+5:msb+1];

   // State, program counter and active-cycle counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FETCH;
         pc_r    <= {(msb+1){1'b0}};
         count_r <= 16'd0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         count_r <= count_s;
      end
   end

   // Next-state, PC advance and opcode decode; decode is only live in EXEC.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      operand_s    = {(msb+1){1'b0}};
      op_s         = 1'b0;
      sel_a_s      = 2'd0;
      sel_b_s      = 1'b0;
      dec_wr_acc_s = 1'b0;
      dec_wr_ram_s = 1'b0;
      dec_rd_ram_s = 1'b0;
      case (state_r)
         ST_FETCH: begin
            if (run) begin
               state_s = ST_EXEC;
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_EXEC: begin
            operand_s = instr[msb:0];
            case (opcode_s)
               OP_STO: dec_wr_ram_s = 1'b1;
               OP_LD: begin
                  dec_rd_ram_s = 1'b1;
                  dec_wr_acc_s = 1'b1;
                  sel_a_s      = 2'd0;
               end
               OP_LDI: begin
                  dec_wr_acc_s = 1'b1;
                  sel_a_s      = 2'd1;
               end
               OP_ADD: begin
                  dec_rd_ram_s = 1'b1;
                  dec_wr_acc_s = 1'b1;
                  sel_a_s      = 2'd2;
                  sel_b_s      = 1'b0;
                  op_s         = 1'b1;
               end
               OP_ADDI: begin
                  dec_wr_acc_s = 1'b1;
                  sel_a_s      = 2'd2;
                  sel_b_s      = 1'b1;
                  op_s         = 1'b1;
               end
               OP_SUB: begin
                  dec_rd_ram_s = 1'b1;
                  dec_wr_acc_s = 1'b1;
                  sel_a_s      = 2'd2;
                  sel_b_s      = 1'b0;
                  op_s         = 1'b0;
               end
               OP_SUBI: begin
                  dec_wr_acc_s = 1'b1;
                  sel_a_s      = 2'd2;
                  sel_b_s      = 1'b1;
                  op_s         = 1'b0;
               end
               default: op_s = 1'b0;
            endcase
            // A stalled EXEC holds PC and state so the instruction replays whole.
            if (run) begin
               if (opcode_s == OP_HLT) begin
                  state_s = ST_HALT;
               end else begin
                  state_s = ST_FETCH;
                  pc_s    = pc_r + PC_ONE;
               end
            end else begin
               state_s = ST_EXEC;
            end
         end
         ST_HALT: state_s = ST_HALT;
         default: state_s = ST_FETCH;
      endcase
      if (run && (state_r != ST_HALT) && (count_r != 16'hFFFF)) begin
         count_s = count_r + 16'd1;
      end else begin
         count_s = count_r;
      end
   end

   assign pm_addr     = pc_r;
   assign operand     = operand_s;
   assign op          = op_s;
   assign sel_a       = sel_a_s;
   assign sel_b       = sel_b_s;
   assign wr_acc      = dec_wr_acc_s & run;
   assign wr_ram      = dec_wr_ram_s & run;
   assign rd_ram      = dec_rd_ram_s & run;
   assign halted      = (state_r == ST_HALT);
   assign cycle_count = count_r;

endmodule

// File: doc/bip_control.md
# bip_control

Instruction-sequencing control unit for the BIP datapath, sitting directly upstream of the BAU add/subtract unit. It owns the program counter and fetches 16-bit instructions from a synchronous program memory. It decodes each opcode and drives the BAU `op` select, the accumulator/operand muxes, and the data-memory strobes. It also runs a two-phase FETCH/EXEC state machine and halts on HLT.

## Interface
- `msb`, default 10: data/address MSB; PC, operand and data width are `msb+1` bits. Opcode field is fixed at 5 bits.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  advance enable; low freezes the FSM, PC and counter.
- `instr`  in  msb+6  program-memory read data. `instr[msb+5:msb+1]` is the opcode and `instr[msb:0]` is the operand. Valid one cycle after `pm_addr`.
- `pm_addr`  out  msb+1  program-memory address, equal to the PC.
- `operand`  out  msb+1  `instr[msb:0]` in EXEC; 0 otherwise. Feeds the data-memory address and the immediate path.
- `op`  out  1  BAU operation: 1 = add, 0 = subtract.
- `sel_a`  out  2  accumulator input mux: 0 = data memory, 1 = immediate operand, 2 = BAU result.
- `sel_b`  out  1  BAU B-input mux: 0 = data memory, 1 = immediate operand.
- `wr_acc`  out  1  accumulator write strobe.
- `wr_ram`  out  1  data-memory write strobe.
- `rd_ram`  out  1  data-memory read strobe.
- `halted`  out  1  high while in HALT.
- `cycle_count`  out  16  number of active cycles executed.

## Operation
- **States**
  - FETCH: `pm_addr` = PC. With `run`=1, go to EXEC next cycle.
  - EXEC: `instr` is valid and decoded combinationally. With `run`=1:
    - HLT: go to HALT; PC is unchanged.
    - Any other opcode: PC <= PC+1, then go to FETCH.
  - HALT: terminal state; leave only via reset.
- **Decode (EXEC only)**: every strobe not listed is 0; `op` defaults to 0, `sel_a`/`sel_b` default to 0.
  - 00000 HLT: no strobes.
  - 00001 STO: `wr_ram`=1.
  - 00010 LD: `rd_ram`=1, `wr_acc`=1, `sel_a`=0.
  - 00011 LDI: `wr_acc`=1, `sel_a`=1.
  - 00100 ADD: `rd_ram`=1, `wr_acc`=1, `sel_a`=2, `sel_b`=0, `op`=1.
  - 00101 ADDI: `wr_acc`=1, `sel_a`=2, `sel_b`=1, `op`=1.
  - 00110 SUB: `rd_ram`=1, `wr_acc`=1, `sel_a`=2, `sel_b`=0, `op`=0.
  - 00111 SUBI: `wr_acc`=1, `sel_a`=2, `sel_b`=1, `op`=0.
  - 01000–11111: NOP. No strobes, PC increments.
- **Strobe gating**: all strobes (`wr_acc`, `wr_ram`, `rd_ram`) are 0 in FETCH, in HALT, and whenever `run`=0.
- **PC**: `msb+1` bits, unsigned. Wraps from all-ones to 0 with no flag.
- **cycle_count**: increments by 1 on every cycle where `run`=1 and the state is FETCH or EXEC, including the EXEC of HLT. Saturates at 16'hFFFF. Frozen in HALT.

## Timing
- **Reset values**: state = FETCH, PC = 0, `pm_addr` = 0, `operand` = 0, `op` = 0, `sel_a` = 0, `sel_b` = 0, all strobes = 0, `halted` = 0, `cycle_count` = 0.
- **Reset assertion**: takes effect immediately, even mid-EXEC. Any strobe in progress drops the same cycle.
- **Instruction timing**: each non-HLT instruction takes exactly 2 active cycles. Strobes are valid for exactly one cycle (EXEC). The accumulator and RAM commit on the rising edge that ends EXEC.
- **`instr` stability**: `pm_addr` is held through EXEC, so `instr` must stay stable until that edge.
- **`halted` assertion**: rises on the first cycle after the HLT EXEC edge. `pm_addr` then holds the HLT address.
- **`run` deassertion**: if `run` drops during EXEC, the strobes drop combinationally and the instruction re-executes fully once `run` returns. No partial commit.

## Test plan
- **Reset**: hold `rst_n`=0 with random `instr` -> all outputs at their reset values; `pm_addr`=0.
- **Basic program**: ROM = {LDI 5, ADDI 3, STO 7, HLT}, `run`=1 continuous ->
  - Cycle 1: `wr_acc`=1, `sel_a`=1, `operand`=5.
  - Cycle 3: `sel_a`=2, `sel_b`=1, `op`=1, `operand`=3.
  - Cycle 5: `wr_ram`=1, `operand`=7.
  - `halted`=1 from cycle 8; final `pm_addr`=3, `cycle_count`=8.
- **Memory ops and NOP**: ROM = {LD 2, SUB 4, 01010 x, HLT} ->
  - LD EXEC: `rd_ram`=1, `sel_a`=0.
  - SUB EXEC: `rd_ram`=1, `sel_b`=0, `op`=0.
  - 01010 EXEC: all strobes 0, PC 2→3.
  - Halt at `pm_addr`=3.
- **Stall**: drop `run` for 3 cycles during the EXEC of ADDI -> strobes 0 and PC/count frozen for those 3 cycles. ADDI strobes reappear when `run` returns; it executes exactly once.
- **Wrap**: with `msb`=3 and a ROM of all NOPs -> `pm_addr` steps 15 → 0 after 32 cycles; `halted` stays 0.
- **Reset mid-operation**: assert `rst_n`=0 mid-EXEC of STO -> `wr_ram` drops immediately. After release, FETCH at `pm_addr`=0 and `cycle_count`=0.
